imem_responder: RTL and testbench



---
 rtl/imem_responder.sv | 167 ++++++++++++++++
 tb/tb_imem_responder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the IF stage.
// Accepts word fetches, answers after WAIT_CYCLES wait states, flags
// misaligned/out-of-range fetches, supports flush and a program-load port.
// Optional: define IMEM_PERF_CNT_EN to add fetch_cnt/fault_cnt outputs.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_inst,
  output logic [31:0] rsp_addr,
  output logic        rsp_fault,
  input  logic        rsp_ready,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] fault_cnt
`endif
);

  localparam int unsigned IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic [31:0] addr_q;
  logic        accept;
  logic        enter_resp;
  logic [31:0] fetch_addr;
  logic        fetch_fault;
  logic        load_ok;

  logic [31:0] mem [DEPTH_WORDS];

  // Misaligned, below base, or beyond the last word (32-bit wrap included).
  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IW-1:0] word_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return IW'(off >> 2);
  endfunction

  assign req_ready   = ~flush & ((state == S_IDLE) | ((state == S_RESP) & rsp_ready));
  assign accept      = req_valid & req_ready;
  assign rsp_valid   = (state == S_RESP);
  assign fetch_fault = addr_bad(fetch_addr);
  assign load_ok     = load_en & ~addr_bad(load_addr);

  // Next-state, wait counter and response-latch control.
  // With zero wait states the accept edge is also the RESP entry edge, so the
  // fetch address comes straight from req_addr instead of the capture register.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    fetch_addr = addr_q;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state_next = S_RESP;
              enter_resp = 1'b1;
              fetch_addr = req_addr;
            end else begin
              state_next = S_WAIT;
              cnt_next   = WAIT_LOAD;
            end
          end else if (state == S_RESP && rsp_ready) begin
            state_next = S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_next = cnt - 4'd1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the accepted fetch address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
    end
  end

  // Latch the response on RESP entry; memory read sees pre-load contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_inst  <= NOP;
      rsp_addr  <= '0;
      rsp_fault <= 1'b0;
    end else if (enter_resp) begin
      rsp_inst  <= fetch_fault ? NOP : mem[word_index(fetch_addr)];
      rsp_addr  <= fetch_addr;
      rsp_fault <= fetch_fault;
    end
  end

  // Program-load write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[word_index(load_addr)] <= load_data;
    end
  end

`ifdef IMEM_PERF_CNT_EN
  // Completed-handshake and faulted-response counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt <= '0;
      fault_cnt <= '0;
    end else if (rsp_valid && rsp_ready) begin
      fetch_cnt <= fetch_cnt + 32'd1;
      if (rsp_fault) begin
        fault_cnt <= fault_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder: four instances (wait states 0,1,3,2; the last
// with a non-zero base) share one stimulus stream and are checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_imem_responder;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_ready;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rr [N];
  logic        rv [N];
  logic        rf [N];
  logic [31:0] ri [N];
  logic [31:0] ra [N];
`ifdef IMEM_PERF_CNT_EN
  logic [31:0] fc  [N];
  logic [31:0] ftc [N];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int unsigned wof(int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] bof(int i);
    return (i == 3) ? 32'h0000_0100 : 32'h0000_0000;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    imem_responder #(
      .DEPTH_WORDS(DW),
      .BASE_ADDR((g == 3) ? 32'h0000_0100 : 32'h0000_0000),
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 2)
    ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_addr(req_addr),
      .req_ready(rr[g]),
      .flush(flush),
      .rsp_valid(rv[g]),
      .rsp_inst(ri[g]),
      .rsp_addr(ra[g]),
      .rsp_fault(rf[g]),
      .rsp_ready(rsp_ready),
      .load_en(load_en),
      .load_addr(load_addr),
      .load_data(load_data)
`ifdef IMEM_PERF_CNT_EN
      ,
      .fetch_cnt(fc[g]),
      .fault_cnt(ftc[g])
`endif
    );
  end

  // ---------------- behavioural model ----------------
  bit          m_have  [N];
  int unsigned m_left  [N];
  logic [31:0] m_q     [N];
  logic [31:0] m_inst  [N];
  logic [31:0] m_raddr [N];
  logic        m_fault [N];
  logic [31:0] m_fc    [N];
  logic [31:0] m_ftc   [N];
  logic [31:0] mm      [N][DW];

  function automatic bit bad(int i, logic [31:0] a);
    logic [31:0] off;
    off = a - bof(i);
    return (a[1:0] != 2'b00) || (a < bof(i)) || ((off >> 2) >= DW);
  endfunction

  task automatic present(int i);
    m_fault[i] = bad(i, m_q[i]);
    m_inst[i]  = m_fault[i] ? NOP : mm[i][(m_q[i] - bof(i)) >> 2];
    m_raddr[i] = m_q[i];
  endtask

  task automatic model_step();
    bit pres, rdy;
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        m_have[i] = 0; m_left[i] = 0; m_inst[i] = NOP; m_raddr[i] = '0;
        m_fault[i] = 1'b0; m_fc[i] = '0; m_ftc[i] = '0;
      end else begin
        pres = m_have[i] && (m_left[i] == 0);
        rdy  = !flush && (!m_have[i] || (pres && rsp_ready));
        if (pres && rsp_ready) begin
          m_fc[i] = m_fc[i] + 1;
          if (m_fault[i]) m_ftc[i] = m_ftc[i] + 1;
        end
        if (flush) begin
          m_have[i] = 0;
        end else if (req_valid && rdy) begin
          m_have[i] = 1; m_left[i] = wof(i); m_q[i] = req_addr;
          if (m_left[i] == 0) present(i);
        end else if (pres && rsp_ready) begin
          m_have[i] = 0;
        end else if (m_have[i] && m_left[i] > 0) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) present(i);
        end
      end
      if (load_en && !bad(i, load_addr)) mm[i][(load_addr - bof(i)) >> 2] = load_data;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h t=%0t", name, i, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        chk("req_ready", i, 32'(rr[i]),
            32'(!flush && (!m_have[i] || (m_have[i] && m_left[i] == 0 && rsp_ready))));
        chk("rsp_valid", i, 32'(rv[i]), 32'(m_have[i] && m_left[i] == 0));
        chk("rsp_inst",  i, ri[i], m_inst[i]);
        chk("rsp_addr",  i, ra[i], m_raddr[i]);
        chk("rsp_fault", i, 32'(rf[i]), 32'(m_fault[i]));
`ifdef IMEM_PERF_CNT_EN
        chk("fetch_cnt", i, fc[i], m_fc[i]);
        chk("fault_cnt", i, ftc[i], m_ftc[i]);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0; rsp_ready = 1'b1; flush = 1'b0; load_en = 1'b0;
    repeat (6) tick();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 32'($urandom_range(0, 127)) << 2;
    if (r == 6) return 32'($urandom_range(0, 511));
    if (r == 7) return 32'hFFFF_FFFC;
    if (r == 8) return $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'h0000_00FC;
      1:       return 32'h0000_0100;
      2:       return 32'h0000_01FC;
      default: return 32'h0000_0200;
    endcase
  endfunction

  initial begin
    bit seen;
    logic [31:0] f0;
    reset = 1'b0; req_valid = 1'b1; req_addr = 32'h8; flush = 1'b0;
    rsp_ready = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;

    // Reset with a pending request
    tick(); tick();
    chk("rst_valid", 0, 32'(rv[0]), 32'd0);
    chk("rst_inst",  0, ri[0], NOP);
    chk("rst_addr",  0, ra[0], 32'd0);
    chk("rst_fault", 0, 32'(rf[0]), 32'd0);
    req_valid = 1'b0;
    reset = 1'b1;

    // Preload both address windows
    for (int a = 0; a < 32'h200; a += 4) begin
      load_en = 1'b1; load_addr = 32'(a);
      load_data = (a == 8) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(a));
      tick();
    end
    drain();

    // Basic fetch latency
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    chk("w0_valid", 0, 32'(rv[0]), 32'd1);
    chk("w0_inst",  0, ri[0], 32'h0050_0093);
    chk("w1_early", 1, 32'(rv[1]), 32'd0);
    tick();
    chk("w1_valid", 1, 32'(rv[1]), 32'd1);
    chk("w1_inst",  1, ri[1], 32'h0050_0093);
    chk("w1_addr",  1, ra[1], 32'h8);
    drain();

    // Back-to-back, zero wait states
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_addr = 32'(k * 4);
      tick();
      chk("b2b_valid", 0, 32'(rv[0]), 32'd1);
      chk("b2b_addr",  0, ra[0], 32'(k * 4));
      chk("b2b_inst",  0, ri[0], (k == 2) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(k * 4)));
    end
    drain();

    // Backpressure
    req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b0;
    tick();
    req_addr = 32'h14;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 0, 32'(rv[0]), 32'd1);
      chk("bp_addr",  0, ra[0], 32'h10);
      chk("bp_inst",  0, ri[0], 32'hC0DE_0010);
      chk("bp_ready", 0, 32'(rr[0]), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release", 0, 32'(rr[0]), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_next_addr", 0, ra[0], 32'h14);
    chk("bp_next_inst", 0, ri[0], 32'hC0DE_0014);
    drain();

    // Faults
`ifdef IMEM_PERF_CNT_EN
    f0 = ftc[0];
`else
    f0 = '0;
`endif
    req_valid = 1'b1; req_addr = 32'h6;
    tick();
    req_valid = 1'b0;
    chk("mis_fault", 0, 32'(rf[0]), 32'd1);
    chk("mis_inst",  0, ri[0], NOP);
    tick();
    req_valid = 1'b1; req_addr = 32'h100;
    tick();
    req_valid = 1'b0;
    chk("oor_fault", 0, 32'(rf[0]), 32'd1);
    chk("oor_inst",  0, ri[0], NOP);
    tick();
`ifdef IMEM_PERF_CNT_EN
    chk("fault_cnt_delta", 0, ftc[0] - f0, 32'd2);
`endif
    drain();

    // Flush during wait states
    req_valid = 1'b1; req_addr = 32'h10;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("flush_quiet", 2, 32'(rv[2]), 32'd0);
      tick();
    end
    req_valid = 1'b1; req_addr = 32'h14;
    tick();
    req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      if (rv[2]) seen = 1;
      else tick();
    end
    chk("flush_resp_seen", 2, 32'(seen), 32'd1);
    chk("flush_resp_inst", 2, ri[2], 32'hC0DE_0014);
    chk("flush_resp_addr", 2, ra[2], 32'h14);
    drain();

    // Randomized traffic
    repeat (4000) begin
      reset     = ($urandom_range(0, 399) != 0);
      req_valid = ($urandom_range(0, 9) < 7);
      req_addr  = rand_addr();
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      load_en   = ($urandom_range(0, 4) == 0);
      load_addr = ($urandom_range(0, 9) == 0) ? rand_addr() : (32'($urandom_range(0, 127)) << 2);
      load_data = $urandom;
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
